// File: rtl/spi_fwm_sram_arb.sv
// rtl/spi_fwm_sram_arb.sv - SRAM port arbiter with read-return routing (option: SPI_FWM_SRAM_ARB_PRIO_EN)
module spi_fwm_sram_arb #(
  parameter int NumReq         = 3,
  parameter int SramAw         = 11,
  parameter int SramDw         = 32,
  parameter int MaxOutstanding = 2
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NumReq-1:0]                     req_i,
  input  logic [NumReq-1:0]                     req_write_i,
  input  logic [NumReq*SramAw-1:0]              req_addr_i,
  input  logic [NumReq*SramDw-1:0]              req_wdata_i,
  output logic [NumReq-1:0]                     req_gnt_o,
  output logic [NumReq-1:0]                     req_rvalid_o,
  output logic [SramDw-1:0]                     req_rdata_o,
  output logic [1:0]                            req_error_o,
  output logic                                  sram_req_o,
  output logic                                  sram_write_o,
  output logic [SramAw-1:0]                     sram_addr_o,
  output logic [SramDw-1:0]                     sram_wdata_o,
  input  logic                                  sram_gnt_i,
  input  logic                                  sram_rvalid_i,
  input  logic [SramDw-1:0]                     sram_rdata_i,
  input  logic [1:0]                            sram_error_i,
  output logic                                  unexp_rvalid_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);

  localparam int IdW  = (NumReq > 1) ? $clog2(NumReq) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
`ifdef SPI_FWM_SRAM_ARB_PRIO_EN
  localparam bit PrioEn = 1'b1;
`else
  localparam bit PrioEn = 1'b0;
`endif

  logic [IdW-1:0]    rr_q, rr_d;
  logic [IdW-1:0]    ids_q [MaxOutstanding];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   cnt_q;
  logic              unexp_q;

  logic              full, empty, push, pop, granted, found;
  logic [NumReq-1:0] elig, win_oh;
  logic [IdW-1:0]    win;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + PtrW'(1);
  endfunction

  // Eligibility: reads need a free tracking slot (judged on the registered count)
  always_comb begin
    full  = (cnt_q == CntW'(MaxOutstanding));
    empty = (cnt_q == '0);
    elig  = rst_i ? '0 : (req_i & (req_write_i | {NumReq{~full}}));
  end

  // Winner selection: optional strict requester 0, then scan rr..NumReq-1 followed by 0..rr-1
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    if (PrioEn && elig[0]) begin
      found     = 1'b1;
      win_oh[0] = 1'b1;
    end
    for (int k = 0; k < NumReq; k++) begin
      if (!found && elig[k] && (k >= int'(rr_q)) && !(PrioEn && k == 0)) begin
        found     = 1'b1;
        win       = IdW'(k);
        win_oh[k] = 1'b1;
      end
    end
    for (int k = 0; k < NumReq; k++) begin
      if (!found && elig[k] && (k < int'(rr_q)) && !(PrioEn && k == 0)) begin
        found     = 1'b1;
        win       = IdW'(k);
        win_oh[k] = 1'b1;
      end
    end
  end

  // SRAM request mux and grant fan-back
  always_comb begin
    sram_req_o   = found;
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (win_oh[k]) begin
        sram_write_o = req_write_i[k];
        sram_addr_o  = req_addr_i[k*SramAw +: SramAw];
        sram_wdata_o = req_wdata_i[k*SramDw +: SramDw];
      end
    end
    granted   = sram_gnt_i & found;
    req_gnt_o = granted ? win_oh : '0;
    push      = granted & ~sram_write_o;
    pop       = sram_rvalid_i & ~empty & ~rst_i;
    rr_d      = rr_q;
    if (granted && !(PrioEn && win == '0)) begin
      rr_d = (win == IdW'(NumReq - 1)) ? '0 : win + IdW'(1);
    end
  end

  // Read-return routing: the head of the tracking FIFO owns the returning beat
  always_comb begin
    req_rvalid_o = '0;
    for (int k = 0; k < NumReq; k++) begin
      if (pop && ids_q[rptr_q] == IdW'(k)) begin
        req_rvalid_o[k] = 1'b1;
      end
    end
    req_rdata_o    = sram_rdata_i;
    req_error_o    = sram_error_i;
    unexp_rvalid_o = unexp_q;
    outstanding_o  = cnt_q;
  end

  // Round-robin pointer, tracking FIFO and sticky unexpected-rvalid flag
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_q    <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      unexp_q <= 1'b0;
      for (int i = 0; i < MaxOutstanding; i++) begin
        ids_q[i] <= '0;
      end
    end else begin
      rr_q <= rr_d;
      if (push) begin
        ids_q[wptr_q] <= win;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      if (push && !pop) begin
        cnt_q <= cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (sram_rvalid_i && empty) begin
        unexp_q <= 1'b1;
      end
    end
  end

endmodule
